// File: rtl/kyber_poly_compress_if.sv
// kyber_poly_compress_if: coefficient-in / byte-out bus bundle for the ciphertext compressor
interface kyber_poly_compress_if #(
  parameter int DEPTH = 8
);
  logic set;
  logic readin;
  logic full_in;
  logic d_sel;
  logic [15:0] comp_din_1;
  logic [15:0] comp_din_2;
  logic [DEPTH-1:0] in_index;
  logic readout;
  logic [7:0] comp_dout;
  logic [8:0] out_index;
  logic dout_valid;
  logic readin_ok;
  logic done;
  modport master (
    output set, readin, full_in, d_sel, comp_din_1, comp_din_2, in_index, readout,
    input comp_dout, out_index, dout_valid, readin_ok, done
  );
  modport slave (
    input set, readin, full_in, d_sel, comp_din_1, comp_din_2, in_index, readout,
    output comp_dout, out_index, dout_valid, readin_ok, done
  );
endinterface

// File: rtl/kyber_poly_compress.sv
// kyber_poly_compress: buffers one polynomial, compresses each coefficient to d bits and streams packed bytes
module kyber_poly_compress #(
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic reset,
  kyber_poly_compress_if.slave bus
);
  localparam int PAIRS = 2 ** (DEPTH - 1);
  localparam logic [8:0] LAST4 = 9'(PAIRS - 1);
  localparam logic [8:0] LAST10 = 9'(PAIRS * 5 / 2 - 1);
  typedef enum logic [1:0] {LOAD, COMP, DONE} state_t;
  state_t state;
  logic [31:0] mem [PAIRS];
  logic [31:0] rd_data;
  logic rd_vld;
  logic d4;
  logic [DEPTH-1:0] fetch_addr;
  logic [31:0] acc;
  logic [31:0] acc_next;
  logic [31:0] new_bits;
  logic [5:0] cnt;
  logic [5:0] cnt_sh;
  logic [5:0] cnt_next;
  logic [5:0] pair_bits;
  logic [9:0] c0;
  logic [9:0] c1;
  logic xfer;
  logic last_xfer;
  logic fetch;

  // One conditional subtract brings x into 0..3328, then round(x * 2^d / q) by constant division
  function automatic logic [9:0] compress(input logic [15:0] x, input logic dsel);
    logic [15:0] r;
    logic [23:0] n;
    logic [9:0] q;
    r = (x >= 16'd3329) ? x - 16'd3329 : x;
    n = (dsel ? {4'd0, r, 4'd0} : {r[13:0], 10'd0}) + 24'd1664;
    q = 10'(n / 24'd3329);
    return dsel ? {6'd0, q[3:0]} : q;
  endfunction

  // Packing datapath: drain a byte on transfer, append the arriving pair above the remaining bits
  always_comb begin
    c0 = compress(rd_data[15:0], d4);
    c1 = compress(rd_data[31:16], d4);
    pair_bits = d4 ? 6'd8 : 6'd20;
    new_bits = d4 ? {24'd0, c1[3:0], c0[3:0]} : {12'd0, c1, c0};
    xfer = bus.dout_valid & bus.readout;
    last_xfer = xfer & (bus.out_index == (d4 ? LAST4 : LAST10));
    cnt_sh = xfer ? cnt - 6'd8 : cnt;
    cnt_next = rd_vld ? cnt_sh + pair_bits : cnt_sh;
    acc_next = (xfer ? acc >> 8 : acc) | (rd_vld ? new_bits << cnt_sh : 32'd0);
    fetch = ~fetch_addr[DEPTH-1] & (cnt_next <= 6'd12);
  end

  // Pair buffer: written only while loading, read every enabled cycle at the fetch address
  always_ff @(posedge clk)
    if (bus.set && !reset) begin
      if (state == LOAD && bus.readin) mem[bus.in_index[DEPTH-1:1]] <= {bus.comp_din_2, bus.comp_din_1};
      rd_data <= mem[fetch_addr[DEPTH-2:0]];
    end

  // Control FSM with the accumulator, fetch pointer and registered handshake outputs
  always_ff @(posedge clk)
    if (reset) begin
      state <= LOAD;
      d4 <= 1'b0;
      fetch_addr <= '0;
      rd_vld <= 1'b0;
      acc <= '0;
      cnt <= '0;
      bus.comp_dout <= '0;
      bus.out_index <= '0;
      bus.dout_valid <= 1'b0;
      bus.readin_ok <= 1'b1;
      bus.done <= 1'b0;
    end else if (bus.set)
      case (state)
        LOAD: begin
          bus.done <= 1'b0;
          if (bus.full_in) begin
            state <= COMP;
            d4 <= bus.d_sel;
            fetch_addr <= '0;
            rd_vld <= 1'b0;
            acc <= '0;
            cnt <= '0;
            bus.comp_dout <= '0;
            bus.out_index <= '0;
            bus.readin_ok <= 1'b0;
          end
        end
        COMP: begin
          fetch_addr <= fetch_addr + DEPTH'(fetch);
          rd_vld <= fetch;
          acc <= acc_next;
          cnt <= cnt_next;
          bus.comp_dout <= acc_next[7:0];
          bus.dout_valid <= ~last_xfer & (cnt_next >= 6'd8);
          bus.out_index <= bus.out_index + 9'(xfer & ~last_xfer);
          if (last_xfer) begin
            state <= DONE;
            bus.done <= 1'b1;
          end
        end
        default: begin
          state <= LOAD;
          bus.done <= 1'b0;
          bus.readin_ok <= 1'b1;
        end
      endcase
endmodule

// File: doc/kyber_poly_compress.md
# kyber_poly_compress

- Ciphertext compression and packing stage of `kyber_pke_enc`, directly downstream of `polyvec_basemul_acc_mont`.
- Buffers one 256-coefficient polynomial, delivered as coefficient pairs. Compresses each coefficient to d bits (d=10 for u, d=4 for v).
- Packs the result little-endian into a byte stream and hands bytes out under a valid/ready handshake.
- Output goes to the ciphertext output port.

## Interface
Parameters:
- DEPTH, 8, coefficient index width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; dominates set.
- set  in  1  clock enable; when low, all state, buffer and outputs hold.
- readin  in  1  write one coefficient pair into the buffer.
- full_in  in  1  last pair is present or already written; start compression.
- d_sel  in  1  0 → d=10 (320 bytes), 1 → d=4 (128 bytes); sampled on full_in acceptance.
- comp_din_1  in  16  coefficient at index in_index.
- comp_din_2  in  16  coefficient at index in_index+1.
- in_index  in  DEPTH  even coefficient index; pair address = in_index[DEPTH-1:1].
- readout  in  1  downstream ready for a byte.
- comp_dout  out  8  packed ciphertext byte.
- out_index  out  9  byte position, 0..319.
- dout_valid  out  1  comp_dout/out_index valid.
- readin_ok  out  1  buffer accepting pairs.
- done  out  1  one-cycle pulse when the polynomial has been fully emitted.

## Operation
- States: LOAD, COMP, DONE. Reset state is LOAD.
- Buffer: 128 x 32-bit RAM, pair per word. Contents are not cleared by reset or done.
- LOAD:
  - readin_ok=1.
  - A pair is written when set & readin; writes may arrive in any address order.
  - set & full_in → latch d_sel, clear counters, go to COMP.
  - readin in the same cycle as full_in still writes that pair.
- COMP:
  - readin_ok=0; readin and full_in are ignored.
  - Pairs are fetched in address order 0..127 (1-cycle RAM read latency).
  - Per coefficient x: if x ≥ 3329 then x ← x − 3329 (single conditional subtract).
  - Then c = ((x<<d) + 1664) / 3329, integer floor, masked to d bits.
  - The result must be bit-exact for all x in 0..6657. A reciprocal multiply is allowed only if bit-exact. Inputs > 6657 give unspecified c.
  - Packing: 32-bit bit accumulator with a bit count. Pair appended as c0 then c1, LSB-first; byte emitted from the accumulator LSBs.
  - d=10: bytes per 4 coeffs = {c0[7:0]}, {c1[5:0],c0[9:8]}, {c2[3:0],c1[9:6]}, {c3[1:0],c2[9:4]}, {c3[9:2]}.
  - d=4: byte k = {c(2k+1), c(2k)}.
  - Fetch issued only when bits-in-accumulator plus bits-in-flight ≤ 12, so the accumulator never overflows.
  - dout_valid=1 whenever count ≥ 8. A transfer occurs on dout_valid & readout; then count −= 8 and out_index += 1.
  - Last byte transferred (out_index 319 for d=10, 127 for d=4) → DONE.
- DONE: done=1 for exactly one cycle, dout_valid=0, then LOAD.

## Timing
- Reset values:
  - State and counters: state=LOAD, counters 0, accumulator empty.
  - Outputs: comp_dout=0, out_index=0, dout_valid=0, readin_ok=1, done=0.
- Reset mid-COMP aborts; the next cycle is LOAD and no partial output is emitted.
- First dout_valid no later than 4 enabled cycles after the full_in-accept edge.
- With readout held high, done asserts within 136 cycles (d=4) or 330 cycles (d=10) of full_in acceptance.
- While dout_valid & ~readout, comp_dout/out_index are held stable and fetching continues only within the ≤12-bit rule.
- set low freezes everything, including the handshake; no transfer occurs on a cycle with set=0.
- Registered outputs: comp_dout, out_index, dout_valid, done, readin_ok.

## Test plan
- Reset, then write all pairs = (0,0), full_in, d_sel=1, readout=1:
  - 128 bytes of 0x00 with out_index 0..127, one done pulse, readin_ok=1 after done.
- d_sel=1, coefficient pairs (208, 1665) everywhere:
  - c=(1,8), every byte = 0x81.
  - Then x=3328 → c=0, and x=3329+208 → c=1.
- d_sel=0, coefficients 1665,1,3328,1665 repeating:
  - c=512,0,0,512.
  - Bytes repeating 0x00,0x02,0x00,0x00,0x80, with 320 bytes total and out_index ending at 319.
- Backpressure, d=10: readout toggled randomly, with set low for 10 cycles mid-stream:
  - Byte sequence identical to the unstalled run.
  - No duplicates or drops.
  - Held data stable while stalled.
- Pairs written in reverse address order, plus readin and full_in asserted in the same cycle:
  - Output identical to the in-order write.
  - readin during COMP does not alter the buffer.
- reset asserted at out_index=100 in COMP:
  - Next cycle LOAD, dout_valid=0, readin_ok=1, no done pulse.
  - A fresh full_in then produces the full stream from out_index 0.
